// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and constants for the pushbutton conditioner
package btn_pkg;

    localparam int CNT_W = 27;

    localparam logic [CNT_W-1:0] DEF_DEBOUNCE_CYCLES = 27'd1_000_000;
    localparam logic [CNT_W-1:0] DEF_HOLD_CYCLES     = 27'd50_000_000;
    localparam logic [CNT_W-1:0] DEF_REPEAT_CYCLES   = 27'd10_000_000;

    typedef enum logic [1:0] {
        ST_RELEASED   = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_RELEASE_DB = 2'd3
    } btn_state_t;

    // The debounced level is high while the press is accepted, even mid-release-debounce.
    function automatic logic is_held(input btn_state_t st);
        return (st == ST_PRESSED) || (st == ST_RELEASE_DB);
    endfunction

endpackage

// File: rtl/btn_if.sv
// rtl/btn_if.sv - raw button levels in, conditioned level/event vectors out
interface btn_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] pb_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_repeat;

    modport master (
        output pb_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  pb_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: two-flop synchronizer, debounce FSM, hold/auto-repeat counter
module btn_channel
    import btn_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [CNT_W-1:0] HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter logic [CNT_W-1:0] REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pb_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    logic             sync_q;
    logic             s;
    btn_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] hcnt, hcnt_n;
    logic             press_n, rel_n, rep_n, level_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= 1'b0;
            s           <= 1'b0;
            state       <= ST_RELEASED;
            cnt         <= '0;
            hcnt        <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_repeat  <= 1'b0;
        end else begin
            sync_q      <= pb_raw;
            s           <= sync_q;
            state       <= state_n;
            cnt         <= cnt_n;
            hcnt        <= hcnt_n;
            btn_level   <= level_n;
            btn_press   <= press_n;
            btn_release <= rel_n;
            btn_repeat  <= rep_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hcnt_n  = hcnt;
        press_n = 1'b0;
        rel_n   = 1'b0;
        rep_n   = 1'b0;

        // Hold timer runs through release debounce; after the first pulse it
        // reloads so the next terminal count is REPEAT_CYCLES away.
        if (is_held(state)) begin
            if (hcnt == HOLD_CYCLES - 27'd1) begin
                hcnt_n = HOLD_CYCLES - REPEAT_CYCLES;
            end else begin
                hcnt_n = hcnt + 27'd1;
            end
        end

        case (state)
            ST_RELEASED: begin
                if (s) begin
                    state_n = ST_PRESS_DB;
                    cnt_n   = '0;
                end
            end
            ST_PRESS_DB: begin
                if (!s) begin
                    state_n = ST_RELEASED;
                    cnt_n   = '0;
                end else if (cnt == DEBOUNCE_CYCLES - 27'd1) begin
                    state_n = ST_PRESSED;
                    cnt_n   = '0;
                    hcnt_n  = '0;
                    press_n = 1'b1;
                end else begin
                    cnt_n = cnt + 27'd1;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_n = ST_RELEASE_DB;
                    cnt_n   = '0;
                end
            end
            ST_RELEASE_DB: begin
                if (s) begin
                    state_n = ST_PRESSED;
                    cnt_n   = '0;
                end else if (cnt == DEBOUNCE_CYCLES - 27'd1) begin
                    state_n = ST_RELEASED;
                    cnt_n   = '0;
                    rel_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 27'd1;
                end
            end
            default: begin
                state_n = ST_RELEASED;
                cnt_n   = '0;
            end
        endcase

        level_n = is_held(state_n);
        rep_n   = is_held(state) && is_held(state_n) && (hcnt_n == HOLD_CYCLES - 27'd1);
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - NUM_BTN independent debounced pushbutton channels
module button_conditioner
    import btn_pkg::*;
#(
    parameter int               NUM_BTN         = 4,
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [CNT_W-1:0] HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter logic [CNT_W-1:0] REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    btn_if.slave bus
);

    logic [NUM_BTN-1:0] level_v;
    logic [NUM_BTN-1:0] press_v;
    logic [NUM_BTN-1:0] release_v;
    logic [NUM_BTN-1:0] repeat_v;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .pb_raw      (bus.pb_raw[i]),
            .btn_level   (level_v[i]),
            .btn_press   (press_v[i]),
            .btn_release (release_v[i]),
            .btn_repeat  (repeat_v[i])
        );
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = release_v;
    assign bus.btn_repeat  = repeat_v;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed and random checks of button_conditioner against a timing model
module tb_button_conditioner;

    localparam int NB = 4;
    localparam int D  = 4;
    localparam int H  = 10;
    localparam int R  = 5;

    logic clk = 1'b0;
    logic reset_n;

    btn_if #(.NUM_BTN(NB)) bus ();

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (27'd4),
        .HOLD_CYCLES     (27'd10),
        .REPEAT_CYCLES   (27'd5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: sampled raw history, accepted level, length of the current
    // disagreeing run, and edges elapsed since the press was accepted.
    logic [NB-1:0] m_sync, m_s, m_lvl;
    int            m_run [NB];
    int            m_age [NB];
    logic [NB-1:0] e_level, e_press, e_release, e_repeat;

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sync = '0; m_s = '0; m_lvl = '0;
        e_level = '0; e_press = '0; e_release = '0; e_repeat = '0;
        for (int i = 0; i < NB; i++) begin
            m_run[i] = 0;
            m_age[i] = 0;
        end
    endtask

    // A change is accepted once the synchronized input has disagreed with the
    // accepted level on D+1 consecutive edges; repeats fall at ages H-1, H-1+R, ...
    task automatic model_edge(input logic [NB-1:0] pb);
        for (int i = 0; i < NB; i++) begin
            e_press[i] = 1'b0; e_release[i] = 1'b0; e_repeat[i] = 1'b0;
            m_run[i] = (m_s[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == D + 1) begin
                m_lvl[i] = m_s[i];
                m_run[i] = 0;
                m_age[i] = 0;
                if (m_lvl[i]) e_press[i] = 1'b1;
                else          e_release[i] = 1'b1;
            end else if (m_lvl[i]) begin
                m_age[i]++;
                if (m_age[i] >= H - 1 && ((m_age[i] - (H - 1)) % R) == 0) e_repeat[i] = 1'b1;
            end
            e_level[i] = m_lvl[i];
            m_s[i]    = m_sync[i];
            m_sync[i] = pb[i];
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".level"},   bus.btn_level,   e_level);
        check({tag, ".press"},   bus.btn_press,   e_press);
        check({tag, ".release"}, bus.btn_release, e_release);
        check({tag, ".repeat"},  bus.btn_repeat,  e_repeat);
        check({tag, ".press_and_repeat"}, bus.btn_press & bus.btn_repeat, '0);
    endtask

    // Called at a negedge; drives pb, lets one rising edge happen, checks, returns at next negedge.
    task automatic step(input logic [NB-1:0] pb, input string tag);
        bus.pb_raw = pb;
        @(posedge clk);
        model_edge(pb);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        int rep_cnt;
        int rel_cnt;
        logic [NB-1:0] cur;

        reset_n    = 1'b0;
        bus.pb_raw = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Clean press and release on channel 0
        for (int k = 1; k <= 12; k++) begin
            step(4'b0001, "clean_press");
            if (k == 6) check("press0_not_before_e7", {3'b0, bus.btn_press[0]}, 4'b0000);
            if (k == 7) check("press0_at_e7", {3'b0, bus.btn_press[0]}, 4'b0001);
            if (k == 8) check("level0_after", {3'b0, bus.btn_level[0]}, 4'b0001);
        end
        for (int k = 1; k <= 10; k++) begin
            step(4'b0000, "clean_release");
            if (k == 7) check("release0_at_e7", {3'b0, bus.btn_release[0]}, 4'b0001);
        end

        // Bounce on channel 1, then steady
        for (int k = 1; k <= 8; k++) step((((k - 1) / 2) % 2 == 0) ? 4'b0010 : 4'b0000, "bounce");
        for (int k = 1; k <= 12; k++) begin
            step(4'b0010, "bounce_settle");
            if (k == 7) check("press1_after_bounce", {2'b0, bus.btn_press[1], 1'b0}, 4'b0010);
        end
        for (int k = 1; k <= 10; k++) step(4'b0000, "bounce_release");

        // Hold channel 2 for auto-repeat, release accepted before the sixth repeat
        rep_cnt = 0;
        rel_cnt = 0;
        for (int k = 1; k <= 45; k++) begin
            step((k <= 33) ? 4'b0100 : 4'b0000, "hold");
            rep_cnt += int'(bus.btn_repeat[2]);
            rel_cnt += int'(bus.btn_release[2]);
            if (k == 7) check("press2", {1'b0, bus.btn_press[2], 2'b0}, 4'b0100);
            if (k >= 16 && k <= 36 && (k - 16) % 5 == 0)
                check($sformatf("repeat2_rel%0d", k), {1'b0, bus.btn_repeat[2], 2'b0}, 4'b0100);
            if (k == 40) check("release2", {1'b0, bus.btn_release[2], 2'b0}, 4'b0100);
        end
        check("repeat2_count", 4'(rep_cnt), 4'd5);
        check("release2_count", 4'(rel_cnt), 4'd1);

        // All four pressed on the same edge
        for (int k = 1; k <= 10; k++) begin
            step(4'b1111, "all_press");
            if (k == 7) check("press_all", bus.btn_press, 4'b1111);
        end

        // Reset while held: outputs drop at once, no release pulse
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_level",   bus.btn_level,   4'b0000);
        check("rst_async_release", bus.btn_release, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        reset_n = 1'b1;

        // Re-press after reset, with a one-cycle release glitch on channel 0
        for (int k = 1; k <= 30; k++) begin
            step((k == 12) ? 4'b1110 : 4'b1111, "repress_glitch");
            if (k == 7) check("press3_after_reset", {bus.btn_press[3], 3'b0}, 4'b1000);
            if (k >= 8) check("glitch_level", bus.btn_level, 4'b1111);
            if (k == 16 || k == 21 || k == 26) check("glitch_repeat", bus.btn_repeat, 4'b1111);
        end

        // Random toggling, held for random durations
        cur = 4'b1111;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 5) == 0) cur[i] = ~cur[i];
            step(cur, "random");
        end
        for (int k = 0; k < 12; k++) step(4'b0000, "final_release");
        check("final_level", bus.btn_level, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
